flash_prog_ctrl: RTL and testbench
==================================

Name: flash_prog_ctrl

Overview:
Program-side controller for the flash controller datapath. It pops words from the program FIFO and issues one flash program request per word at consecutive addresses. It counts words and reports done and error. On a flash or address-overflow error it drains the rest of the operation's words from the FIFO without programming them, so the FIFO and software stay in step.

Parameters:
AddrW, 10, flash word-address width
DataW, 32, flash data word width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
op_start_i  in  1  program operation active (level, held by op control until op_done_o)
op_num_words_i  in  12  words in operation minus 1 (0 = one word)
op_addr_i  in  AddrW  start word address
op_done_o  out  1  one-cycle pulse: operation complete
op_err_o  out  1  valid with op_done_o: operation saw an error
data_rdy_i  in  1  program FIFO not empty
data_i  in  DataW  program FIFO head
data_rd_o  out  1  program FIFO pop (one word per cycle asserted)
flash_req_o  out  1  flash program request
flash_addr_o  out  AddrW  flash program address
flash_ovfl_o  out  1  address computation carried past AddrW
flash_data_o  out  DataW  flash program data
flash_done_i  in  1  flash program transaction complete
flash_error_i  in  1  valid with flash_done_i: transaction failed

Behaviour:
- Reset is asynchronous and active-low: st=StNorm, cnt=0, err_q=0. All outputs are combinational from state and inputs, so none carry a register of their own. With idle inputs, all 1-bit outputs are 0 during and after reset.
- Address: int_addr[AddrW:0] = op_addr_i + cnt (cnt truncated to AddrW bits, zero-extended result). flash_addr_o = int_addr[AddrW-1:0]; flash_ovfl_o = int_addr[AddrW].
- flash_data_o = data_i, combinational pass-through. The FIFO head stays stable until popped.
- cnt_hit = (cnt == op_num_words_i). txn_done = flash_req_o & flash_done_i.
- StNorm:
  - flash_req_o = op_start_i & data_rdy_i & ~flash_ovfl_o.
  - Overflow case: if op_start_i & data_rdy_i & flash_ovfl_o, there is no request. Pop the word (data_rd_o=1) and set err_q.
    - If cnt_hit: op_done_o=1, op_err_o=1, cnt=0, err_q cleared.
    - Else: cnt+1, go to StErr.
  - txn_done & cnt_hit: pop, op_done_o=1, op_err_o = flash_error_i | err_q, cnt=0, err_q=0.
  - txn_done & ~cnt_hit: pop, cnt+1.
    - If flash_error_i: set err_q, go to StErr.
  - The pop occurs only on completion. The request is held (level) until flash_done_i, and flash_done_i without flash_req_o is ignored.
- StErr (drain):
  - flash_req_o = 0. data_rd_o = data_rdy_i.
  - data_rdy_i & cnt_hit: op_done_o=1, op_err_o=1, cnt=0, err_q=0, go to StNorm.
  - data_rdy_i & ~cnt_hit: cnt+1.
  - Stays in StErr regardless of op_start_i.
- Latency: one word completes per flash_done_i. At most one pop per cycle. op_done_o is coincident with the last pop.
- Width: cnt is 12 bits and wraps only if op_num_words_i=0xFFF (4096 words); no special handling.
- Deasserting op_start_i mid-operation in StNorm stalls requests but keeps cnt; resuming continues at the same address.
- Reset mid-operation returns to StNorm with cnt=0 immediately. The FIFO is not popped.
- Simultaneous flash_error_i on the last word: done with err, no StErr entry.

Decomposition:
- Shared flash_ctrl package: state enum {StNorm, StErr} (1 bit), and AddrW/DataW defaults shared with the read controller.
- No sub-module is needed. The address adder and the counter are inline.

Test Plan:
- op_addr=0x010, num_words=3, data_rdy=1, flash_done after 2 cycles each, no error → 4 requests at 0x010..0x013, data_o matches FIFO, 4 pops; op_done on 4th pop, op_err=0; cnt returns to 0.
- num_words=0, single word → one request at op_addr; op_done and pop in the same cycle as flash_done.
- num_words=4, flash_error_i on 2nd word → StErr; remaining 3 words popped with flash_req_o=0; op_done with op_err=1 on the 5th pop; next op runs cleanly with op_err=0.
- op_addr=0x3FE, num_words=3, AddrW=10 → requests at 0x3FE, 0x3FF; then flash_ovfl_o=1, no request, word popped, StErr drains the last word; op_done with op_err=1.
- data_rdy_i toggled 1/0 and op_start_i dropped for 5 cycles mid-op → no request while either is low; address and count preserved; total pops = num_words+1.
- rst_ni asserted while a request is pending at cnt=2 → flash_req_o drops when op_start_i is deasserted; after release cnt=0, st=StNorm, no spurious op_done.

Source files
------------

// File: rtl/flash_prog_ctrl_pkg.sv
// Shared flash controller definitions.
// Holds the default flash geometry used by both the program and read
// controllers, the operation word-count width, and the program-side FSM
// state encodings.
package flash_prog_ctrl_pkg;

    localparam int DefAddrW = 10;   // flash word-address width
    localparam int DefDataW = 32;   // flash data word width
    localparam int CntW     = 12;   // op word count width (num_words field)

    // Program controller states (1 bit, legacy-compatible constants)
    localparam logic StNorm = 1'b0; // issuing program requests
    localparam logic StErr  = 1'b1; // draining FIFO after an error

endpackage

// File: rtl/flash_prog_ctrl.sv
// Program-side flash controller.
// Pops words from the program FIFO and issues one flash program request per
// word at consecutive word addresses starting at op_addr_i. After a flash
// error or an address overflow, the remaining words of the operation are
// popped without being programmed, so the FIFO stays aligned with software.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   op_start_i             operation active (level)
//   op_num_words_i         words in operation minus one
//   op_addr_i              start word address
//   op_done_o, op_err_o    completion pulse and its error status
//   data_rdy_i, data_i     program FIFO not-empty and head word
//   data_rd_o              program FIFO pop
//   flash_req_o            flash program request (held until flash_done_i)
//   flash_addr_o           flash program address
//   flash_ovfl_o           address computation carried past AddrW
//   flash_data_o           flash program data
//   flash_done_i           flash program transaction complete
//   flash_error_i          transaction failed (valid with flash_done_i)
module flash_prog_ctrl
    import flash_prog_ctrl_pkg::*;
#(
    parameter int AddrW = DefAddrW,
    parameter int DataW = DefDataW
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              op_start_i,
    input  logic [CntW-1:0]   op_num_words_i,
    input  logic [AddrW-1:0]  op_addr_i,
    output logic              op_done_o,
    output logic              op_err_o,
    input  logic              data_rdy_i,
    input  logic [DataW-1:0]  data_i,
    output logic              data_rd_o,
    output logic              flash_req_o,
    output logic [AddrW-1:0]  flash_addr_o,
    output logic              flash_ovfl_o,
    output logic [DataW-1:0]  flash_data_o,
    input  logic              flash_done_i,
    input  logic              flash_error_i
);

    logic              r_st;
    logic [CntW-1:0]   r_cnt;
    logic              r_err;

    logic              w_st_nxt;
    logic [CntW-1:0]   w_cnt_nxt;
    logic              w_err_nxt;

    logic [AddrW:0]    w_cnt_ext;
    logic [AddrW:0]    w_int_addr;
    logic              w_ovfl;
    logic              w_cnt_hit;
    logic              w_req;
    logic              w_txn_done;
    logic              w_rd;
    logic              w_done;
    logic              w_op_err;

    // Count is truncated to AddrW bits before the add; the extra result bit
    // exposes the carry out as the overflow indication.
    always_comb begin
        w_cnt_ext        = (AddrW+1)'(r_cnt);
        w_cnt_ext[AddrW] = 1'b0;
    end

    assign w_int_addr = {1'b0, op_addr_i} + w_cnt_ext;
    assign w_ovfl     = w_int_addr[AddrW];
    assign w_cnt_hit  = (r_cnt == op_num_words_i);

    assign w_req      = (r_st == StNorm) & op_start_i & data_rdy_i & ~w_ovfl;
    // flash_done_i without an outstanding request is ignored
    assign w_txn_done = w_req & flash_done_i;

    always_comb begin
        w_st_nxt  = r_st;
        w_cnt_nxt = r_cnt;
        w_err_nxt = r_err;
        w_rd      = 1'b0;
        w_done    = 1'b0;
        w_op_err  = 1'b0;

        if (r_st == StNorm) begin
            if (op_start_i & data_rdy_i & w_ovfl) begin
                // Address ran off the end: consume the word, never program it
                w_rd = 1'b1;
                if (w_cnt_hit) begin
                    w_done    = 1'b1;
                    w_op_err  = 1'b1;
                    w_cnt_nxt = '0;
                    w_err_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    w_err_nxt = 1'b1;
                    w_st_nxt  = StErr;
                end
            end else if (w_txn_done) begin
                // Word leaves the FIFO only once flash has accepted it
                w_rd = 1'b1;
                if (w_cnt_hit) begin
                    // Error on the last word finishes directly, no drain needed
                    w_done    = 1'b1;
                    w_op_err  = flash_error_i | r_err;
                    w_cnt_nxt = '0;
                    w_err_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (flash_error_i) begin
                        w_err_nxt = 1'b1;
                        w_st_nxt  = StErr;
                    end
                end
            end
        end else begin
            // Drain: pop whatever the FIFO offers until the op's words are gone.
            // op_start_i is not consulted so the drain always completes.
            w_rd = data_rdy_i;
            if (data_rdy_i) begin
                if (w_cnt_hit) begin
                    w_done    = 1'b1;
                    w_op_err  = 1'b1;
                    w_cnt_nxt = '0;
                    w_err_nxt = 1'b0;
                    w_st_nxt  = StNorm;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_st  <= StNorm;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_st  <= w_st_nxt;
            r_cnt <= w_cnt_nxt;
            r_err <= w_err_nxt;
        end
    end

    assign op_done_o    = w_done;
    assign op_err_o     = w_op_err;
    assign data_rd_o    = w_rd;
    assign flash_req_o  = w_req;
    assign flash_addr_o = w_int_addr[AddrW-1:0];
    assign flash_ovfl_o = w_ovfl;
    assign flash_data_o = data_i;

endmodule

// File: tb/tb_flash_prog_ctrl.sv
// Scoreboard bench for flash_prog_ctrl: a FIFO model feeds words, a flash
// responder completes each request two cycles after it is seen, and expected
// program transactions / op results are queued at op launch.
module tb_flash_prog_ctrl;

    localparam int AW = 10;
    localparam int DW = 32;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          op_start_i;
    logic [11:0]   op_num_words_i;
    logic [AW-1:0] op_addr_i;
    logic          op_done_o;
    logic          op_err_o;
    logic          data_rdy_i;
    logic [DW-1:0] data_i;
    logic          data_rd_o;
    logic          flash_req_o;
    logic [AW-1:0] flash_addr_o;
    logic          flash_ovfl_o;
    logic [DW-1:0] flash_data_o;
    logic          flash_done_i;
    logic          flash_error_i;

    flash_prog_ctrl #(.AddrW(AW), .DataW(DW)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .op_start_i     (op_start_i),
        .op_num_words_i (op_num_words_i),
        .op_addr_i      (op_addr_i),
        .op_done_o      (op_done_o),
        .op_err_o       (op_err_o),
        .data_rdy_i     (data_rdy_i),
        .data_i         (data_i),
        .data_rd_o      (data_rd_o),
        .flash_req_o    (flash_req_o),
        .flash_addr_o   (flash_addr_o),
        .flash_ovfl_o   (flash_ovfl_o),
        .flash_data_o   (flash_data_o),
        .flash_done_i   (flash_done_i),
        .flash_error_i  (flash_error_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int fails  = 0;

    logic [DW-1:0] fifo[$];
    txn_t          exp_txn[$];
    logic          exp_res[$];
    logic          rdy_en;
    int            err_word;
    int            txn_idx;
    int            pops;
    int            ovfl_cnt;
    int            busy;
    bit            done_seen;
    bit            obs_req;
    bit            pop_pend;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void upd_fifo();
        data_rdy_i = (fifo.size() > 0) && rdy_en;
        data_i     = (fifo.size() > 0) ? fifo[0] : '0;
    endfunction

    // Observe what the coming posedge will act on
    task automatic monitor();
        txn_t t;
        obs_req  = flash_req_o;
        pop_pend = data_rd_o;
        if (rst_ni && (!op_start_i || !data_rdy_i))
            chk("req_gate", flash_req_o, 0);
        if (flash_ovfl_o) begin
            chk("ovfl_noreq", flash_req_o, 0);
            ovfl_cnt++;
        end
        if (flash_req_o && flash_done_i) begin
            if (exp_txn.size() == 0) chk("txn_unexp", flash_req_o & flash_done_i, 0);
            else begin
                t = exp_txn.pop_front();
                chk("addr", flash_addr_o, t.addr);
                chk("data", flash_data_o, t.data);
            end
            txn_idx++;
        end
        if (op_done_o) begin
            chk("done_pop", data_rd_o, 1);
            if (exp_res.size() == 0) chk("done_unexp", op_done_o, 0);
            else chk("op_err", op_err_o, exp_res.pop_front());
            done_seen = 1'b1;
        end
        if (data_rd_o) pops++;
    endtask

    task automatic cycle();
        @(negedge clk_i);
        monitor();
        @(posedge clk_i);
        #1;
        if (pop_pend && fifo.size() > 0) void'(fifo.pop_front());
        if (flash_done_i) begin
            flash_done_i  = 1'b0;
            flash_error_i = 1'b0;
            busy = 0;
        end else if (obs_req) begin
            busy++;
            if (busy >= 2) begin
                flash_done_i  = 1'b1;
                flash_error_i = (txn_idx == err_word);
            end
        end else begin
            busy = 0;
        end
        upd_fifo();
    endtask

    task automatic start_op(input logic [AW-1:0] addr, input int num, input int ew);
        logic [AW:0] a;
        bit err;
        busy = 0; txn_idx = 0; pops = 0; ovfl_cnt = 0; done_seen = 1'b0;
        err_word = ew;
        for (int i = 0; i <= num; i++) fifo.push_back($urandom);
        err = 1'b0;
        for (int i = 0; i <= num; i++) begin
            a = {1'b0, addr} + (AW+1)'(i);
            if (!err) begin
                if (a[AW]) err = 1'b1;
                else begin
                    exp_txn.push_back('{addr: a[AW-1:0], data: fifo[i]});
                    if (i == ew) err = 1'b1;
                end
            end
        end
        exp_res.push_back(err);
        op_addr_i      = addr;
        op_num_words_i = 12'(num);
        op_start_i     = 1'b1;
        rdy_en         = 1'b1;
        upd_fifo();
    endtask

    task automatic run_op(input logic [AW-1:0] addr, input int num, input int ew, input bit stall);
        bit exp_ovfl;
        exp_ovfl = (int'(addr) + num) >= (1 << AW);
        start_op(addr, num, ew);
        for (int c = 0; c < 400 && !done_seen; c++) begin
            if (stall) begin
                rdy_en     = !(c >= 3 && c < 11 && (c % 2) == 1);
                op_start_i = !(c >= 12 && c < 17);
                upd_fifo();
            end
            cycle();
        end
        if (!done_seen) chk("timeout", done_seen, 1);
        op_start_i = 1'b0;
        rdy_en     = 1'b1;
        upd_fifo();
        chk("pops", pops, num + 1);
        chk("txn_left", exp_txn.size(), 0);
        chk("fifo_left", fifo.size(), 0);
        chk("ovfl_seen", ovfl_cnt != 0, exp_ovfl);
    endtask

    initial begin
        rst_ni = 1'b0; op_start_i = 1'b0; op_num_words_i = '0; op_addr_i = '0;
        flash_done_i = 1'b0; flash_error_i = 1'b0; rdy_en = 1'b1; err_word = -1;
        txn_idx = 0; pops = 0; ovfl_cnt = 0; busy = 0; done_seen = 1'b0;
        obs_req = 1'b0; pop_pend = 1'b0;
        upd_fifo();
        #3;
        chk("rst_done", op_done_o, 0);
        chk("rst_rd",   data_rd_o, 0);
        chk("rst_req",  flash_req_o, 0);
        chk("rst_ovfl", flash_ovfl_o, 0);
        chk("rst_err",  op_err_o, 0);
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        repeat (2) cycle();
        chk("idle_done", op_done_o, 0);
        chk("idle_req",  flash_req_o, 0);
        chk("idle_rd",   data_rd_o, 0);

        run_op(10'h010, 3, -1, 1'b0);   // four clean words
        run_op(10'h055, 0, -1, 1'b0);   // single word
        run_op(10'h020, 4,  1, 1'b0);   // flash error on 2nd word, drain 3
        run_op(10'h030, 2, -1, 1'b0);   // clean after error
        run_op(10'h3FE, 3, -1, 1'b0);   // address overflow on 3rd word
        run_op(10'h080, 7, -1, 1'b1);   // rdy toggling and op_start stall

        // Reset while a request is pending at cnt=2
        start_op(10'h100, 5, -1);
        for (int c = 0; c < 100; c++) begin
            cycle();
            if (txn_idx == 2 && flash_req_o) break;
        end
        chk("rst_pend_req", flash_req_o, 1);
        chk("rst_pend_addr", flash_addr_o, 10'h102);
        op_start_i = 1'b0;
        #1;
        chk("rst_reqdrop", flash_req_o, 0);
        rst_ni = 1'b0;
        #1;
        chk("inrst_req",  flash_req_o, 0);
        chk("inrst_rd",   data_rd_o, 0);
        chk("inrst_done", op_done_o, 0);
        fifo.delete(); exp_txn.delete(); exp_res.delete();
        flash_done_i = 1'b0; flash_error_i = 1'b0; busy = 0;
        upd_fifo();
        repeat (2) cycle();
        rst_ni = 1'b1;
        done_seen = 1'b0;
        repeat (5) cycle();
        chk("no_spur_done", done_seen, 0);
        run_op(10'h100, 1, -1, 1'b0);   // restarts at op_addr, so cnt was cleared

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0t exp=<200000", $time);
        $fatal(1);
    end

endmodule
